// File: rtl/video_sys_led_ctrl.sv
// Avalon-MM LED output port: DATA/BLINK_EN/PERIOD registers, atomic set/clear,
// and per-bit blinking driven by a programmable half-period prescaler.
module video_sys_led_ctrl #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       CNT_W       = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_BLINK  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wr_bits      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Register write decode; set/clear are read-modify-write on DATA.
  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = wr_bits;
        ADDR_BLINK:  blink_d  = wr_bits;
        ADDR_PERIOD: period_d = writedata[CNT_W-1:0];
        ADDR_OUTSET: data_d   = data_q | wr_bits;
        ADDR_OUTCLR: data_d   = data_q & ~wr_bits;
        default:     data_d   = data_q;
      endcase
    end
  end

  // Prescaler: a PERIOD write restarts the half-period so the counter never overruns.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && (address == ADDR_PERIOD)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == (period_q - CNT_W'(1))) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // Zero-latency read mux; write-only and reserved words read as zero.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_q);
      ADDR_BLINK:  readdata = 32'(blink_q);
      ADDR_PERIOD: readdata = 32'(period_q);
      ADDR_STATUS: readdata = 32'(phase_q);
      default:     readdata = 32'd0;
    endcase
  end

  assign out_port = data_q & (~blink_q | {WIDTH{phase_q}});

endmodule

// File: tb/tb_video_sys_led_ctrl.sv
// Scoreboard bench for video_sys_led_ctrl: stimulus queues expected out_port/readdata,
// a negedge monitor pops and compares.
module tb_video_sys_led_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  logic        obs_valid = 1'b0;
  string       name_q[$];
  logic [7:0]  eo_q[$];
  logic [31:0] er_q[$];
  int          checks = 0;
  int          errors = 0;

  video_sys_led_ctrl #(
    .WIDTH       (8),
    .CNT_W       (24),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [2:0] a,
                     input logic [7:0] eo, input logic [31:0] er);
    address = a;
    name_q.push_back(nm);
    eo_q.push_back(eo);
    er_q.push_back(er);
    obs_valid = 1'b1;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    string       nm;
    logic [7:0]  eo;
    logic [31:0] er;
    if (obs_valid) begin
      checks++;
      if (name_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: out_port=%h readdata=%h with empty scoreboard",
                 out_port, readdata);
      end else begin
        nm = name_q.pop_front();
        eo = eo_q.pop_front();
        er = er_q.pop_front();
        if (out_port !== eo || readdata !== er) begin
          errors++;
          $display("FAIL %s: got out_port=%h readdata=%h, expected out_port=%h readdata=%h",
                   nm, out_port, readdata, eo, er);
        end
      end
    end
  end

  initial begin
    logic ph;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("rst_data", 3'd0, 8'h00, 32'h0);
    chk("rst_blink", 3'd1, 8'h00, 32'h0);
    chk("rst_period", 3'd2, 8'h00, 32'h0);
    chk("rst_status", 3'd5, 8'h00, 32'h1);

    wr(3'd0, 32'hFFFF_FF3C);
    chk("data_wr", 3'd0, 8'h3C, 32'h3C);
    wr(3'd6, 32'hFF);
    chk("rsv6", 3'd6, 8'h3C, 32'h0);
    chk("rsv7", 3'd7, 8'h3C, 32'h0);

    wr(3'd0, 32'hA0);
    wr(3'd3, 32'h0F);
    chk("outset", 3'd0, 8'hAF, 32'hAF);
    wr(3'd4, 32'h81);
    chk("outclr", 3'd0, 8'h2E, 32'h2E);
    chk("rd_outset", 3'd3, 8'h2E, 32'h0);
    chk("rd_outclr", 3'd4, 8'h2E, 32'h0);

    // Blink, half-period 4: four cycles on, four off
    wr(3'd0, 32'h03);
    wr(3'd1, 32'h01);
    chk("blink_en_rd", 3'd1, 8'h03, 32'h1);
    wr(3'd2, 32'd4);
    for (int i = 0; i < 16; i++) begin
      ph = ((i / 4) % 2) == 0;
      chk($sformatf("p4_c%0d", i), 3'd5, ph ? 8'h03 : 8'h02, {31'd0, ph});
    end
    chk("period_rd", 3'd2, 8'h03, 32'd4);

    // Half-period 1: toggles every cycle
    wr(3'd2, 32'd1);
    for (int i = 0; i < 6; i++) begin
      ph = (i % 2) == 0;
      chk($sformatf("p1_c%0d", i), 3'd5, ph ? 8'h03 : 8'h02, {31'd0, ph});
    end

    // Stop blinking while phase is low
    wr(3'd2, 32'd4);
    for (int i = 0; i < 6; i++) begin
      ph = i < 4;
      chk($sformatf("pre_stop_c%0d", i), 3'd5, ph ? 8'h03 : 8'h02, {31'd0, ph});
    end
    wr(3'd2, 32'd0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("stopped_c%0d", i), 3'd5, 8'h03, 32'h1);
    chk("stopped_period", 3'd2, 8'h03, 32'h0);

    // Async reset in the middle of a low phase
    wr(3'd2, 32'd2);
    chk("pre_rst_c0", 3'd5, 8'h03, 32'h1);
    chk("pre_rst_c1", 3'd5, 8'h03, 32'h1);
    chk("pre_rst_c2", 3'd5, 8'h02, 32'h0);
    reset_n = 1'b0;
    chk("mid_rst_out", 3'd0, 8'h00, 32'h0);
    reset_n = 1'b1;
    chk("post_rst_blink", 3'd1, 8'h00, 32'h0);
    chk("post_rst_period", 3'd2, 8'h00, 32'h0);
    chk("post_rst_status", 3'd5, 8'h00, 32'h1);
    wr(3'd0, 32'h55);
    chk("post_rst_data", 3'd0, 8'h55, 32'h55);

    for (int n = 0; n < 10 && name_q.size() != 0; n++) @(posedge clk);
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected samples never observed, expected 0", name_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
